// File: rtl/video_pkg.sv
// Shared constants and source encodings for the DVI video path.
package video_pkg;

    localparam int unsigned H_PIXELS    = 800;
    localparam int unsigned V_LINES     = 600;
    localparam int unsigned PIXEL_WIDTH = 24;

    // ActiveSrc encodings double as the scheduler state encoding.
    typedef enum logic [1:0] {
        SRC_PATTERN = 2'd0,
        SRC_FEATURE = 2'd1,
        SRC_BLANK   = 2'd2
    } active_src_e;

    localparam logic [PIXEL_WIDTH-1:0] BLACK_PIXEL = 24'h000000;

endpackage

// File: rtl/pixel_position_counter.sv
// Raster x/y position tracker advancing on each pixel transfer, with a
// last-pixel flag, a one-cycle frame-done pulse and a wrapping frame count.
module pixel_position_counter #(
    parameter int unsigned H_PIXELS        = video_pkg::H_PIXELS,
    parameter int unsigned V_LINES         = video_pkg::V_LINES,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_transfer,
    output logic [9:0]                 o_pixel_x,
    output logic [9:0]                 o_pixel_y,
    output logic                       o_last_pixel,
    output logic                       o_frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] o_frame_count
);

    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [9:0] Y_LAST = 10'(V_LINES - 1);

    logic [9:0]                 r_x;
    logic [9:0]                 r_y;
    logic                       r_frame_done;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
    logic                       w_x_last;
    logic                       w_last_pixel;

    assign w_x_last     = (r_x == X_LAST);
    assign w_last_pixel = w_x_last && (r_y == Y_LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= i_transfer && w_last_pixel;
            if (i_transfer) begin
                if (w_x_last) begin
                    r_x <= 10'd0;
                    r_y <= w_last_pixel ? 10'd0 : r_y + 10'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
                if (w_last_pixel) begin
                    r_frame_count <= r_frame_count + FRAME_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign o_pixel_x     = r_x;
    assign o_pixel_y     = r_y;
    assign o_last_pixel  = w_last_pixel;
    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;

endmodule

// File: rtl/video_source_scheduler.sv
// Frame-synchronous mux between the pattern generator, the feature output
// and a black frame; the source only changes on the last-pixel transfer.
module video_source_scheduler #(
    parameter int unsigned H_PIXELS        = video_pkg::H_PIXELS,
    parameter int unsigned V_LINES         = video_pkg::V_LINES,
    parameter int unsigned PIXEL_WIDTH     = video_pkg::PIXEL_WIDTH,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       SelReq,
    input  logic                       BlankReq,
    input  logic [PIXEL_WIDTH-1:0]     Src0Video,
    input  logic                       Src0Valid,
    output logic                       Src0Ready,
    input  logic [PIXEL_WIDTH-1:0]     Src1Video,
    input  logic                       Src1Valid,
    output logic                       Src1Ready,
    input  logic                       VideoReady,
    output logic                       VideoValid,
    output logic [PIXEL_WIDTH-1:0]     Video,
    output logic [1:0]                 ActiveSrc,
    output logic [9:0]                 PixelX,
    output logic [9:0]                 PixelY,
    output logic                       FrameStart,
    output logic                       FrameDone,
    output logic [FRAME_CNT_WIDTH-1:0] FrameCount
);

    import video_pkg::*;

    active_src_e            r_state;
    active_src_e            w_state_next;
    logic                   w_video_valid;
    logic [PIXEL_WIDTH-1:0] w_video;
    logic                   w_src0_ready;
    logic                   w_src1_ready;
    logic                   w_transfer;
    logic                   w_last_pixel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SRC_PATTERN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_video_valid = 1'b0;
        w_video       = PIXEL_WIDTH'(BLACK_PIXEL);
        w_src0_ready  = 1'b0;
        w_src1_ready  = 1'b0;

        case (r_state)
            SRC_PATTERN: begin
                w_video_valid = Src0Valid;
                w_video       = Src0Video;
                w_src0_ready  = VideoReady;
            end
            SRC_FEATURE: begin
                w_video_valid = Src1Valid;
                w_video       = Src1Video;
                w_src1_ready  = VideoReady;
            end
            SRC_BLANK: begin
                w_video_valid = 1'b1;
            end
            default: begin
                w_state_next = SRC_PATTERN;
            end
        endcase

        // Handshake is held quiet for the whole time reset is asserted.
        if (reset) begin
            w_video_valid = 1'b0;
            w_video       = '0;
            w_src0_ready  = 1'b0;
            w_src1_ready  = 1'b0;
        end

        w_transfer = w_video_valid && VideoReady;

        if (w_transfer && w_last_pixel) begin
            if (BlankReq) begin
                w_state_next = SRC_BLANK;
            end else if (SelReq) begin
                w_state_next = SRC_FEATURE;
            end else begin
                w_state_next = SRC_PATTERN;
            end
        end
    end

    pixel_position_counter #(
        .H_PIXELS        (H_PIXELS),
        .V_LINES         (V_LINES),
        .FRAME_CNT_WIDTH (FRAME_CNT_WIDTH)
    ) u_position (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_transfer    (w_transfer),
        .o_pixel_x     (PixelX),
        .o_pixel_y     (PixelY),
        .o_last_pixel  (w_last_pixel),
        .o_frame_done  (FrameDone),
        .o_frame_count (FrameCount)
    );

    assign VideoValid = w_video_valid;
    assign Video      = w_video;
    assign Src0Ready  = w_src0_ready;
    assign Src1Ready  = w_src1_ready;
    assign ActiveSrc  = r_state;
    assign FrameStart = (PixelX == 10'd0) && (PixelY == 10'd0);

endmodule

// File: tb/tb_video_source_scheduler.sv
// Directed bench on a shrunken 4x3 raster with a 4-bit frame counter; sources
// emit their own pixel index in the low byte so loss or duplication shows.
module tb_video_source_scheduler;

    localparam int unsigned H   = 4;
    localparam int unsigned V   = 3;
    localparam int unsigned FCW = 4;
    localparam int unsigned NPX = H * V;

    logic           clock;
    logic           reset;
    logic           SelReq;
    logic           BlankReq;
    logic [23:0]    Src0Video;
    logic           Src0Valid;
    logic           Src0Ready;
    logic [23:0]    Src1Video;
    logic           Src1Valid;
    logic           Src1Ready;
    logic           VideoReady;
    logic           VideoValid;
    logic [23:0]    Video;
    logic [1:0]     ActiveSrc;
    logic [9:0]     PixelX;
    logic [9:0]     PixelY;
    logic           FrameStart;
    logic           FrameDone;
    logic [FCW-1:0] FrameCount;

    logic [7:0]     s0_idx;
    logic [7:0]     s1_idx;

    int checks;
    int failures;

    video_source_scheduler #(
        .H_PIXELS        (H),
        .V_LINES         (V),
        .PIXEL_WIDTH     (24),
        .FRAME_CNT_WIDTH (FCW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .SelReq     (SelReq),
        .BlankReq   (BlankReq),
        .Src0Video  (Src0Video),
        .Src0Valid  (Src0Valid),
        .Src0Ready  (Src0Ready),
        .Src1Video  (Src1Video),
        .Src1Valid  (Src1Valid),
        .Src1Ready  (Src1Ready),
        .VideoReady (VideoReady),
        .VideoValid (VideoValid),
        .Video      (Video),
        .ActiveSrc  (ActiveSrc),
        .PixelX     (PixelX),
        .PixelY     (PixelY),
        .FrameStart (FrameStart),
        .FrameDone  (FrameDone),
        .FrameCount (FrameCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Source models share the DUT reset and advance only on their own handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_idx <= 8'd0;
            s1_idx <= 8'd0;
        end else begin
            if (Src0Valid && Src0Ready) s0_idx <= (s0_idx == 8'(NPX - 1)) ? 8'd0 : s0_idx + 8'd1;
            if (Src1Valid && Src1Ready) s1_idx <= (s1_idx == 8'(NPX - 1)) ? 8'd0 : s1_idx + 8'd1;
        end
    end

    assign Src0Video = {16'h00CC, s0_idx};
    assign Src1Video = {16'h1234, s1_idx};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SelReq = 1'b0;
        BlankReq = 1'b0;
        Src0Valid = 1'b1;
        Src1Valid = 1'b1;
        VideoReady = 1'b1;
        tick();
        tick();
        checks++;
        if (VideoValid !== 1'b0 || Src0Ready !== 1'b0 || Src1Ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_handshake got valid=%b r0=%b r1=%b exp 0 0 0",
                     VideoValid, Src0Ready, Src1Ready);
        end
        checks++;
        if (Video !== 24'h0) begin
            failures++;
            $display("FAIL rst_video got=%h exp=000000", Video);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ActiveSrc !== 2'd0 || PixelX !== 10'd0 || PixelY !== 10'd0) begin
            failures++;
            $display("FAIL rst_state got src=%0d x=%0d y=%0d exp 0 0 0", ActiveSrc, PixelX, PixelY);
        end
        checks++;
        if (FrameCount !== 4'd0 || FrameDone !== 1'b0 || FrameStart !== 1'b1) begin
            failures++;
            $display("FAIL rst_frame got cnt=%0d done=%b start=%b exp 0 0 1",
                     FrameCount, FrameDone, FrameStart);
        end
    endtask

    task automatic test_src0_frame();
        for (int i = 0; i < int'(NPX); i++) begin
            #1;
            checks++;
            if (VideoValid !== 1'b1 || Video !== (24'h00CC00 | 24'(i))) begin
                failures++;
                $display("FAIL f1_pixel i=%0d got valid=%b video=%h exp 1 %h",
                         i, VideoValid, Video, 24'h00CC00 | 24'(i));
            end
            checks++;
            if (PixelX !== 10'(i % H) || PixelY !== 10'(i / H)) begin
                failures++;
                $display("FAIL f1_pos i=%0d got x=%0d y=%0d exp %0d %0d", i, PixelX, PixelY,
                         i % H, i / H);
            end
            checks++;
            if (Src0Ready !== 1'b1 || Src1Ready !== 1'b0 || FrameStart !== (i == 0)) begin
                failures++;
                $display("FAIL f1_ctl i=%0d got r0=%b r1=%b start=%b exp 1 0 %b",
                         i, Src0Ready, Src1Ready, FrameStart, i == 0);
            end
            checks++;
            if (FrameDone !== 1'b0) begin
                failures++;
                $display("FAIL f1_done_early i=%0d got=%b exp=0", i, FrameDone);
            end
            tick();
        end
        #1;
        checks++;
        if (FrameDone !== 1'b1 || FrameCount !== 4'd1) begin
            failures++;
            $display("FAIL f1_end got done=%b cnt=%0d exp 1 1", FrameDone, FrameCount);
        end
        checks++;
        if (ActiveSrc !== 2'd0 || PixelX !== 10'd0 || PixelY !== 10'd0) begin
            failures++;
            $display("FAIL f1_wrap got src=%0d x=%0d y=%0d exp 0 0 0", ActiveSrc, PixelX, PixelY);
        end
    endtask

    task automatic test_switch();
        for (int i = 0; i < int'(NPX); i++) begin
            if (i == 5) SelReq = 1'b1;
            #1;
            checks++;
            if (ActiveSrc !== 2'd0 || Video !== (24'h00CC00 | 24'(i))) begin
                failures++;
                $display("FAIL f2_pixel i=%0d got src=%0d video=%h exp 0 %h",
                         i, ActiveSrc, Video, 24'h00CC00 | 24'(i));
            end
            tick();
        end
        #1;
        checks++;
        if (ActiveSrc !== 2'd1 || FrameCount !== 4'd2) begin
            failures++;
            $display("FAIL f2_end got src=%0d cnt=%0d exp 1 2", ActiveSrc, FrameCount);
        end
        checks++;
        if (Video !== 24'h123400 || Src0Ready !== 1'b0 || Src1Ready !== 1'b1) begin
            failures++;
            $display("FAIL f3_first got video=%h r0=%b r1=%b exp 123400 0 1",
                     Video, Src0Ready, Src1Ready);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (Video !== (24'h123400 | 24'(i))) begin
                failures++;
                $display("FAIL f3_pre i=%0d got=%h exp=%h", i, Video, 24'h123400 | 24'(i));
            end
            tick();
        end
        VideoReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (PixelX !== 10'd3 || Src0Ready !== 1'b0 || Src1Ready !== 1'b0 ||
                VideoValid !== 1'b1) begin
                failures++;
                $display("FAIL stall_ready k=%0d got x=%0d r0=%b r1=%b valid=%b exp 3 0 0 1",
                         k, PixelX, Src0Ready, Src1Ready, VideoValid);
            end
            tick();
        end
        VideoReady = 1'b1;
        Src1Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (VideoValid !== 1'b0 || PixelX !== 10'd3 || Src1Ready !== 1'b1) begin
                failures++;
                $display("FAIL stall_valid k=%0d got valid=%b x=%0d r1=%b exp 0 3 1",
                         k, VideoValid, PixelX, Src1Ready);
            end
            tick();
        end
        Src1Valid = 1'b1;
        BlankReq = 1'b1;
        for (int i = 3; i < int'(NPX); i++) begin
            #1;
            checks++;
            if (Video !== (24'h123400 | 24'(i)) || PixelX !== 10'(i % H) ||
                PixelY !== 10'(i / H)) begin
                failures++;
                $display("FAIL f3_post i=%0d got video=%h x=%0d y=%0d exp %h %0d %0d",
                         i, Video, PixelX, PixelY, 24'h123400 | 24'(i), i % H, i / H);
            end
            tick();
        end
        #1;
        checks++;
        if (ActiveSrc !== 2'd2 || FrameCount !== 4'd3) begin
            failures++;
            $display("FAIL f3_end got src=%0d cnt=%0d exp 2 3", ActiveSrc, FrameCount);
        end
    endtask

    task automatic test_blank();
        for (int i = 0; i < int'(NPX); i++) begin
            if (i == 2) BlankReq = 1'b0;
            #1;
            checks++;
            if (VideoValid !== 1'b1 || Video !== 24'h0 || Src0Ready !== 1'b0 ||
                Src1Ready !== 1'b0 || ActiveSrc !== 2'd2) begin
                failures++;
                $display("FAIL blank i=%0d got valid=%b video=%h r0=%b r1=%b src=%0d exp 1 0 0 0 2",
                         i, VideoValid, Video, Src0Ready, Src1Ready, ActiveSrc);
            end
            tick();
        end
        #1;
        checks++;
        if (ActiveSrc !== 2'd1 || FrameCount !== 4'd4 || Video !== 24'h123400) begin
            failures++;
            $display("FAIL blank_end got src=%0d cnt=%0d video=%h exp 1 4 123400",
                     ActiveSrc, FrameCount, Video);
        end
    endtask

    task automatic test_reselect();
        for (int i = 0; i < int'(NPX); i++) begin
            if (i == 6) SelReq = 1'b0;
            #1;
            checks++;
            if (ActiveSrc !== 2'd1 || Video !== (24'h123400 | 24'(i))) begin
                failures++;
                $display("FAIL f5_pixel i=%0d got src=%0d video=%h exp 1 %h",
                         i, ActiveSrc, Video, 24'h123400 | 24'(i));
            end
            tick();
        end
        for (int i = 0; i < int'(NPX); i++) begin
            if (i == 6) SelReq = 1'b1;
            #1;
            checks++;
            if (ActiveSrc !== 2'd0 || Video !== (24'h00CC00 | 24'(i))) begin
                failures++;
                $display("FAIL f6_pixel i=%0d got src=%0d video=%h exp 0 %h",
                         i, ActiveSrc, Video, 24'h00CC00 | 24'(i));
            end
            tick();
        end
        #1;
        checks++;
        if (ActiveSrc !== 2'd1 || FrameCount !== 4'd6) begin
            failures++;
            $display("FAIL f6_end got src=%0d cnt=%0d exp 1 6", ActiveSrc, FrameCount);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) tick();
        #1;
        checks++;
        if (PixelX !== 10'd2 || PixelY !== 10'd1 || ActiveSrc !== 2'd1) begin
            failures++;
            $display("FAIL mid_pos got x=%0d y=%0d src=%0d exp 2 1 1", PixelX, PixelY, ActiveSrc);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (VideoValid !== 1'b0 || Src0Ready !== 1'b0 || Src1Ready !== 1'b0 || Video !== 24'h0) begin
            failures++;
            $display("FAIL mid_rst_out got valid=%b r0=%b r1=%b video=%h exp 0 0 0 0",
                     VideoValid, Src0Ready, Src1Ready, Video);
        end
        checks++;
        if (ActiveSrc !== 2'd0 || PixelX !== 10'd0 || PixelY !== 10'd0) begin
            failures++;
            $display("FAIL mid_rst_async got src=%0d x=%0d y=%0d exp 0 0 0",
                     ActiveSrc, PixelX, PixelY);
        end
        tick();
        reset = 1'b0;
        SelReq = 1'b0;
        #1;
        checks++;
        if (FrameCount !== 4'd0 || FrameDone !== 1'b0 || ActiveSrc !== 2'd0 ||
            Video !== 24'h00CC00) begin
            failures++;
            $display("FAIL mid_release got cnt=%0d done=%b src=%0d video=%h exp 0 0 0 00cc00",
                     FrameCount, FrameDone, ActiveSrc, Video);
        end
    endtask

    task automatic test_frame_wrap();
        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < int'(NPX); i++) tick();
        end
        #1;
        checks++;
        if (FrameCount !== 4'hF) begin
            failures++;
            $display("FAIL wrap_pre got=%0h exp=f", FrameCount);
        end
        for (int i = 0; i < int'(NPX) - 1; i++) tick();
        #1;
        checks++;
        if (PixelX !== 10'd3 || PixelY !== 10'd2 || FrameDone !== 1'b0) begin
            failures++;
            $display("FAIL wrap_last got x=%0d y=%0d done=%b exp 3 2 0", PixelX, PixelY, FrameDone);
        end
        tick();
        #1;
        checks++;
        if (FrameCount !== 4'h0 || FrameDone !== 1'b1) begin
            failures++;
            $display("FAIL wrap_end got cnt=%0h done=%b exp 0 1", FrameCount, FrameDone);
        end
        tick();
        #1;
        checks++;
        if (FrameDone !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pulse got=%b exp=0", FrameDone);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_src0_frame();
        test_switch();
        test_stall();
        test_blank();
        test_reselect();
        test_reset_mid();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
